// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it. The core strobes bytes in
// with no backpressure, and the FSM serialises them as 8N1 frames with no gap between frames.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [8:0]                  uart_in,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [AW:0]   count_s;
   logic          overflow_r;

   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] bit_cnt_r;
   logic [CW-1:0] bit_cnt_s;
   logic [2:0]    bit_idx_r;
   logic [2:0]    bit_idx_s;
   logic [7:0]    shift_r;
   logic [7:0]    shift_s;
   logic          tx_r;
   logic          tx_s;

   logic          strobe_s;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          bit_end_s;

   assign strobe_s  = uart_in[8];
   assign full_s    = (count_r == DEPTH_C);
   assign empty_s   = (count_r == {(AW + 1){1'b0}});
   // A pop at the same edge frees the slot the write lands in, so a full FIFO still accepts.
   assign push_s    = strobe_s && (!full_s || pop_s);
   assign bit_end_s = (bit_cnt_r == CNT_LAST);

   assign tx         = tx_r;
   assign busy       = (state_r != IDLE) || !empty_s;
   assign fifo_count = count_r;
   assign overflow   = overflow_r;

   // Occupancy update from the push/pop pair.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + (AW + 1)'(1);
         2'b01:   count_s = count_r - (AW + 1)'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= uart_in[7:0];
      end
   end

   // FIFO pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {(AW + 1){1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_s;
         if (strobe_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Frame sequencer next-state; tx_s is the level the line takes after this edge.
   always_comb begin
      state_s   = state_r;
      bit_cnt_s = bit_cnt_r;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      tx_s      = tx_r;
      pop_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s     = 1'b1;
               shift_s   = mem_r[rd_ptr_r];
               tx_s      = 1'b0;
               bit_cnt_s = {CW{1'b0}};
               state_s   = START;
            end else begin
               tx_s      = 1'b1;
               bit_cnt_s = {CW{1'b0}};
            end
         end
         START: begin
            if (bit_end_s) begin
               bit_cnt_s = {CW{1'b0}};
               bit_idx_s = 3'd0;
               tx_s      = shift_r[0];
               state_s   = DATA;
            end else begin
               bit_cnt_s = bit_cnt_r + CW'(1);
            end
         end
         DATA: begin
            if (bit_end_s) begin
               bit_cnt_s = {CW{1'b0}};
               if (bit_idx_r == 3'd7) begin
                  tx_s    = 1'b1;
                  state_s = STOP;
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
                  shift_s   = {1'b0, shift_r[7:1]};
                  tx_s      = shift_r[1];
               end
            end else begin
               bit_cnt_s = bit_cnt_r + CW'(1);
            end
         end
         STOP: begin
            if (bit_end_s) begin
               bit_cnt_s = {CW{1'b0}};
               if (!empty_s) begin
                  pop_s   = 1'b1;
                  shift_s = mem_r[rd_ptr_r];
                  tx_s    = 1'b0;
                  state_s = START;
               end else begin
                  tx_s    = 1'b1;
                  state_s = IDLE;
               end
            end else begin
               bit_cnt_s = bit_cnt_r + CW'(1);
            end
         end
         default: begin
            state_s   = IDLE;
            bit_cnt_s = {CW{1'b0}};
            tx_s      = 1'b1;
         end
      endcase
   end

   // Frame sequencer registers, including the registered serial line.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         bit_cnt_r <= {CW{1'b0}};
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
      end else begin
         state_r   <= state_s;
         bit_cnt_r <= bit_cnt_s;
         bit_idx_r <= bit_idx_s;
         shift_r   <= shift_s;
         tx_r      <= tx_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed/randomised bench for uart_tx_fifo: a serial-line monitor captures whole frames,
// and these are compared against waveforms built from the bytes pushed.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;

   logic       clock;
   logic       reset_n;
   logic [8:0] uart_in;
   logic       tx;
   logic       busy;
   logic [4:0] fifo_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0]  exp_q [$];
   logic [39:0] rx_q  [$];
   int          rx_t  [$];

   logic [39:0] mon_w;
   int          mon_t;
   logic        mon_abort;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .uart_in    (uart_in),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Capture 40 line samples from each falling start edge; a reset aborts the frame.
   always begin
      @(negedge clock);
      if (reset_n === 1'b1 && tx === 1'b0) begin
         mon_t     = cyc;
         mon_w     = 40'd0;
         mon_abort = 1'b0;
         for (int i = 1; i < 10 * CPB; i++) begin
            @(negedge clock);
            if (reset_n !== 1'b1) begin
               mon_abort = 1'b1;
               break;
            end
            mon_w[i] = tx;
         end
         if (!mon_abort) begin
            rx_q.push_back(mon_w);
            rx_t.push_back(mon_t);
         end
      end
   end

   function automatic logic [39:0] frame_wave(input logic [7:0] d);
      logic [39:0] w;
      int b;
      w = 40'd0;
      for (int i = 0; i < 10 * CPB; i++) begin
         b = i / CPB;
         if (b == 0)      w[i] = 1'b0;
         else if (b == 9) w[i] = 1'b1;
         else             w[i] = d[b-1];
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic stb, input logic [7:0] d);
      @(negedge clock);
      uart_in = {stb, d};
      @(posedge clock);
      #1;
      uart_in = 9'h000;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step(1'b0, 8'h00);
         n++;
      end
      chk("idle_timeout", busy, 1'b0);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
   endtask

   task automatic check_frames(input string tag);
      logic [7:0] e;
      chk({tag, "_nframes"}, rx_q.size(), exp_q.size());
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         void'(rx_t.pop_front());
         chk({tag, "_frame"}, rx_q.pop_front(), frame_wave(e));
      end
      exp_q.delete();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin
      logic [7:0] d;
      int n;
      int gap;
      int t0;
      uart_in = 9'h000;
      reset_n = 1'b1;

      // Reset takes effect with no clock edge.
      #2 reset_n = 1'b0;
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_count", fifo_count, 5'd0);
      chk("rst_ovf", overflow, 1'b0);
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b1;

      // Single byte 0x41: line low one edge after capture, busy for 40 cycles.
      step(1'b1, 8'h41);
      chk("single_count", fifo_count, 5'd1);
      chk("single_tx_e0", tx, 1'b1);
      chk("single_busy", busy, 1'b1);
      step(1'b0, 8'h00);
      chk("single_tx_e1", tx, 1'b0);
      chk("single_count_e1", fifo_count, 5'd0);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         step(1'b0, 8'h00);
         n++;
      end
      chk("single_busy_len", n, 40);
      exp_q.push_back(8'h41);
      step(1'b0, 8'h00);
      check_frames("single");

      // Back-to-back frames with no idle gap.
      step(1'b1, 8'h55);
      step(1'b1, 8'hAA);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      wait_idle(200);
      if (rx_t.size() >= 2) begin
         t0 = rx_t[1] - rx_t[0];
         chk("b2b_spacing", t0, 10 * CPB);
      end else begin
         chk("b2b_nframes", rx_t.size(), 2);
      end
      check_frames("b2b");

      // Random bursts: pointers wrap several times, order preserved.
      for (int burst = 0; burst < 4; burst++) begin
         for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            step(1'b1, d);
            exp_q.push_back(d);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00);
         end
         wait_idle(600);
         check_frames("wrap");
      end
      chk("wrap_ovf", overflow, 1'b0);

      // Overflow: 18 strobes, first byte leaves at edge 2, 18th is dropped.
      for (int k = 1; k <= 18; k++) begin
         step(1'b1, 8'(k - 1));
         n = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
         chk("ovf_count", fifo_count, n);
         chk("ovf_flag", overflow, (k == 18) ? 1 : 0);
         if (k <= 17) exp_q.push_back(8'(k - 1));
      end
      wait_idle(800);
      chk("ovf_sticky", overflow, 1'b1);
      check_frames("ovf");

      // Reset in DATA bit 3 of the first of three queued bytes.
      d = 8'($urandom) & 8'hF7;
      step(1'b1, d);
      step(1'b1, 8'($urandom));
      step(1'b1, 8'($urandom));
      for (int k = 0; k < 16; k++) step(1'b0, 8'h00);
      chk("mid_tx_bit3", tx, d[3]);
      chk("mid_count", fifo_count, 5'd2);
      #6 reset_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_count", fifo_count, 5'd0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ovf", overflow, 1'b0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      d = 8'($urandom);
      step(1'b1, d);
      chk("post_rst_count", fifo_count, 5'd1);
      step(1'b0, 8'h00);
      chk("post_rst_tx", tx, 1'b0);
      exp_q.push_back(d);
      wait_idle(200);
      check_frames("post_rst");

      // Full FIFO with a strobe on the STOP-end pop edge (edge 42).
      for (int k = 1; k <= 17; k++) begin
         d = 8'($urandom);
         step(1'b1, d);
         exp_q.push_back(d);
      end
      chk("full_count", fifo_count, 5'd16);
      for (int k = 18; k <= 41; k++) step(1'b0, 8'h00);
      chk("full_hold_count", fifo_count, 5'd16);
      d = 8'($urandom);
      step(1'b1, d);
      exp_q.push_back(d);
      chk("full_pop_count", fifo_count, 5'd16);
      chk("full_pop_ovf", overflow, 1'b0);
      wait_idle(900);
      chk("full_end_ovf", overflow, 1'b0);
      check_frames("full");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
